// File: rtl/d_flip_flop.sv
// rtl/d_flip_flop.sv - WIDTH-bit rising-edge D register with synchronous active-high reset
module d_flip_flop #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  output logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic             Reset,
  input  logic             Clock
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  assign q_d = d;

  // Reset wins over data; q is driven straight from the register, no logic after it.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_d_flip_flop.sv
// tb/tb_d_flip_flop.sv - self-checking bench for d_flip_flop
module tb_d_flip_flop;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] d2    = 2'b00;
  logic [3:0] d4    = 4'h0;
  logic       q_b0;
  logic       q_b1;
  logic [1:0] q_w2;
  logic [3:0] q_w4;

  int checks = 0;
  int errors = 0;

  logic [1:0] m2;
  logic [3:0] m4;

  localparam logic [3:0] RV4 = 4'hA;

  always #5 Clock = ~Clock;

  d_flip_flop u_b0 (.q(q_b0), .d(d2[0]), .Reset(Reset), .Clock(Clock));
  d_flip_flop u_b1 (.q(q_b1), .d(d2[1]), .Reset(Reset), .Clock(Clock));
  d_flip_flop #(.WIDTH(2)) u_w2 (.q(q_w2), .d(d2), .Reset(Reset), .Clock(Clock));
  d_flip_flop #(.WIDTH(4), .RESET_VAL(4'hA)) u_w4 (.q(q_w4), .d(d4), .Reset(Reset), .Clock(Clock));

  typedef struct {
    bit         rst;
    logic [1:0] d;
    logic [3:0] d4;
    logic [1:0] exp;
    logic [3:0] exp4;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk($sformatf("%s_cells", tag), {30'd0, q_b1, q_b0}, {30'd0, m2});
    chk($sformatf("%s_w2", tag), {30'd0, q_w2}, {30'd0, m2});
    chk($sformatf("%s_w4", tag), {28'd0, q_w4}, {28'd0, m4});
  endtask

  // Drive on the falling edge, update the reference model, sample 1ns after the rising edge.
  task automatic apply(input bit rst, input logic [1:0] dv, input logic [3:0] d4v);
    @(negedge Clock);
    Reset = rst;
    d2    = dv;
    d4    = d4v;
    m2    = rst ? 2'b00 : dv;
    m4    = rst ? RV4 : d4v;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 2'b11, 4'hF, 2'b00, 4'hA};
    vecs[1]  = '{1'b1, 2'b11, 4'h5, 2'b00, 4'hA};
    vecs[2]  = '{1'b0, 2'b01, 4'h1, 2'b01, 4'h1};
    vecs[3]  = '{1'b0, 2'b00, 4'h0, 2'b00, 4'h0};
    vecs[4]  = '{1'b0, 2'b01, 4'hF, 2'b01, 4'hF};
    vecs[5]  = '{1'b0, 2'b10, 4'h6, 2'b10, 4'h6};
    vecs[6]  = '{1'b0, 2'b11, 4'h9, 2'b11, 4'h9};
    vecs[7]  = '{1'b0, 2'b00, 4'h3, 2'b00, 4'h3};
    vecs[8]  = '{1'b0, 2'b11, 4'hC, 2'b11, 4'hC};
    vecs[9]  = '{1'b1, 2'b11, 4'h7, 2'b00, 4'hA};
    vecs[10] = '{1'b1, 2'b10, 4'h0, 2'b00, 4'hA};
    vecs[11] = '{1'b0, 2'b11, 4'h5, 2'b11, 4'h5};

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].rst, vecs[i].d, vecs[i].d4);
      chk($sformatf("vec%0d_cells", i), {30'd0, q_b1, q_b0}, {30'd0, vecs[i].exp});
      chk($sformatf("vec%0d_w2", i), {30'd0, q_w2}, {30'd0, vecs[i].exp});
      chk($sformatf("vec%0d_w4", i), {28'd0, q_w4}, {28'd0, vecs[i].exp4});
    end

    // A pulse on d that is gone before the rising edge must not reach q.
    apply(1'b0, 2'b00, 4'h0);
    chk_model("glitch_pre");
    @(negedge Clock);
    d2 = 2'b11;
    d4 = 4'hF;
    #1;
    chk_model("glitch_mid");
    #2;
    d2 = 2'b00;
    d4 = 4'h0;
    @(posedge Clock);
    #1;
    chk_model("glitch_post");

    // Reset raised mid-cycle only takes effect at the next rising edge.
    apply(1'b0, 2'b11, 4'h5);
    chk_model("midrst_pre");
    @(negedge Clock);
    #1;
    Reset = 1'b1;
    d2    = 2'b11;
    #1;
    chk_model("midrst_hold");
    m2 = 2'b00;
    m4 = RV4;
    @(posedge Clock);
    #1;
    chk_model("midrst_clear");

    apply(1'b0, 2'b11, 4'hC);
    chk_model("release");

    for (int i = 0; i < 200; i++) begin
      apply($urandom_range(0, 7) == 0, 2'($urandom), 4'($urandom));
      chk_model($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
